fetch_instr_queue: RTL and testbench

Instruction queue between the instruction re-aligner and the decode stage. Each cycle it accepts up to INSTR_PER_FETCH realigned instructions, possibly with gaps in the valid vector. It compacts them into a circular buffer in program order and presents one instruction per cycle to decode over a valid/ready handshake. It decouples fetch bursts from single-issue decode and provides the back-pressure point for the frontend.

---
 rtl/ariane_pkg.sv | 19 +
 rtl/fetch_slot_compact.sv | 22 ++
 rtl/fetch_instr_queue.sv | 100 ++++++++++
 tb/tb_fetch_instr_queue.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ariane_pkg.sv
// Shared frontend types and sizing constants.
// Fetch entries and queue defaults used by the instruction queue.
package ariane_pkg;

  localparam int unsigned INSTR_PER_FETCH   = 4;
  localparam int unsigned FETCH_QUEUE_DEPTH = 8;

  typedef struct packed {
    logic [63:0] addr;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic is_rvc(
    input logic [31:0] instr
  );
    return instr[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/fetch_slot_compact.sv
// Exclusive prefix popcount over a fetch valid vector.
// Gives each set slot its packed position and the total count.
module fetch_slot_compact #(
  parameter int unsigned N  = 4,
  parameter int unsigned CW = $clog2(N + 1)
) (
  input  logic [N-1:0]  valid_i,
  output logic [CW-1:0] offset_o [N],
  output logic [CW-1:0] n_o
);

  always_comb begin : p_prefix
    logic [CW-1:0] acc;
    acc = '0;
    for (int i = 0; i < N; i++) begin
      offset_o[i] = acc;
      acc = acc + CW'(valid_i[i]);
    end
    n_o = acc;
  end

endmodule

// File: rtl/fetch_instr_queue.sv
// Compacting instruction queue between re-aligner and decode.
// Takes up to INSTR_PER_FETCH per cycle, issues one per cycle.
module fetch_instr_queue #(
  parameter int unsigned DEPTH =
    ariane_pkg::FETCH_QUEUE_DEPTH,
  parameter int unsigned INSTR_PER_FETCH =
    ariane_pkg::INSTR_PER_FETCH
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        flush_i,
  input  logic [INSTR_PER_FETCH-1:0] valid_i,
  input  logic [63:0] addr_i  [INSTR_PER_FETCH],
  input  logic [31:0] instr_i [INSTR_PER_FETCH],
  output logic        ready_o,
  output logic        valid_o,
  output logic [63:0] addr_o,
  output logic [31:0] instr_o,
  output logic        is_compressed_o,
  input  logic        ready_i,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  import ariane_pkg::*;

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned SW = $clog2(INSTR_PER_FETCH + 1);

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [SW-1:0] slot_off [INSTR_PER_FETCH];
  logic [SW-1:0] slot_n;
  logic          push, pop;

  fetch_slot_compact #(
    .N  (INSTR_PER_FETCH),
    .CW (SW)
  ) i_compact (
    .valid_i  (valid_i),
    .offset_o (slot_off),
    .n_o      (slot_n)
  );

  // Space is judged on the registered count alone, so a
  // same-cycle pop never opens the door early.
  assign ready_o = count_q <= CW'(DEPTH - INSTR_PER_FETCH);
  assign valid_o = count_q != '0;
  assign push    = ready_o && |valid_i;
  assign pop     = valid_o && ready_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(slot_n);
      count_d  = count_d + CW'(slot_n);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
      count_d  = count_d - CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      if (push) begin
        for (int i = 0; i < INSTR_PER_FETCH; i++) begin
          if (valid_i[i]) begin
            mem_q[PW'(wr_ptr_q + PW'(slot_off[i]))] <=
              '{addr: addr_i[i], instr: instr_i[i]};
          end
        end
      end
    end
  end

  assign addr_o          = mem_q[rd_ptr_q].addr;
  assign instr_o         = mem_q[rd_ptr_q].instr;
  assign is_compressed_o = is_rvc(instr_o);
  assign count_o         = count_q;

endmodule

// File: tb/tb_fetch_instr_queue.sv
// Directed bench for fetch_instr_queue (DEPTH=8, IPF=4).
// Each task drives a scenario and checks hand-computed values.
module tb_fetch_instr_queue;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        flush_i;
  logic [3:0]  valid_i;
  logic [63:0] addr_i  [4];
  logic [31:0] instr_i [4];
  logic        ready_o;
  logic        valid_o;
  logic [63:0] addr_o;
  logic [31:0] instr_o;
  logic        is_compressed_o;
  logic        ready_i;
  logic [3:0]  count_o;

  int pass_cnt = 0;
  int total    = 0;

  fetch_instr_queue #(
    .DEPTH           (8),
    .INSTR_PER_FETCH (4)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .flush_i         (flush_i),
    .valid_i         (valid_i),
    .addr_i          (addr_i),
    .instr_i         (instr_i),
    .ready_o         (ready_o),
    .valid_o         (valid_o),
    .addr_o          (addr_o),
    .instr_o         (instr_o),
    .is_compressed_o (is_compressed_o),
    .ready_i         (ready_i),
    .count_o         (count_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_slots(input logic [63:0] a0,
                           input logic [31:0] i0);
    for (int k = 0; k < 4; k++) begin
      addr_i[k]  = a0 + 64'(4 * k);
      instr_i[k] = i0 + 32'(k);
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1; flush_i = 1'b0;
    valid_i = '0; ready_i = 1'b0;
    set_slots(64'h0, 32'h0);
    step(); step();
    rst_i = 1'b0;
    total++;
    if (valid_o !== 1'b0) $display("FAIL rst_valid got=%0b exp=0", valid_o);
    else pass_cnt++;
    total++;
    if (ready_o !== 1'b1) $display("FAIL rst_ready got=%0b exp=1", ready_o);
    else pass_cnt++;
    total++;
    if (count_o !== 4'd0) $display("FAIL rst_count got=%0d exp=0", count_o);
    else pass_cnt++;
    total++;
    if (addr_o !== 64'h0) $display("FAIL rst_addr got=%h exp=0", addr_o);
    else pass_cnt++;
    total++;
    if (instr_o !== 32'h0) $display("FAIL rst_instr got=%h exp=0", instr_o);
    else pass_cnt++;
    total++;
    if (is_compressed_o !== 1'b1)
      $display("FAIL rst_rvc got=%0b exp=1", is_compressed_o);
    else pass_cnt++;
  endtask

  task automatic test_burst();
    ready_i = 1'b1;
    valid_i = 4'b1111;
    set_slots(64'h1000, 32'h1);
    total++;
    if (valid_o !== 1'b0)
      $display("FAIL burst_no_bypass got=%0b exp=0", valid_o);
    else pass_cnt++;
    step();
    valid_i = '0;
    for (int k = 0; k < 4; k++) begin
      total++;
      if (valid_o !== 1'b1)
        $display("FAIL burst_valid[%0d] got=%0b exp=1", k, valid_o);
      else pass_cnt++;
      total++;
      if (instr_o !== 32'(k + 1))
        $display("FAIL burst_instr[%0d] got=%h exp=%h", k, instr_o, k + 1);
      else pass_cnt++;
      total++;
      if (addr_o !== 64'h1000 + 64'(4 * k))
        $display("FAIL burst_addr[%0d] got=%h exp=%h", k, addr_o,
                 64'h1000 + 64'(4 * k));
      else pass_cnt++;
      total++;
      if (count_o !== 4'(4 - k))
        $display("FAIL burst_count[%0d] got=%0d exp=%0d", k, count_o, 4 - k);
      else pass_cnt++;
      step();
    end
    total++;
    if (count_o !== 4'd0 || valid_o !== 1'b0)
      $display("FAIL burst_empty got=%0d/%0b exp=0/0", count_o, valid_o);
    else pass_cnt++;
    // ready_i held high on empty queue must not move anything
    step();
    total++;
    if (count_o !== 4'd0) $display("FAIL empty_pop got=%0d exp=0", count_o);
    else pass_cnt++;
    ready_i = 1'b0;
  endtask

  task automatic test_sparse();
    valid_i = 4'b1010;
    addr_i[0] = 64'h2000; instr_i[0] = 32'hAAAA_AAA3;
    addr_i[1] = 64'h2004; instr_i[1] = 32'h0000_0013;
    addr_i[2] = 64'h2008; instr_i[2] = 32'hBBBB_BBB3;
    addr_i[3] = 64'h200C; instr_i[3] = 32'h0000_4002;
    step();
    valid_i = '0;
    total++;
    if (count_o !== 4'd2) $display("FAIL sparse_count got=%0d exp=2", count_o);
    else pass_cnt++;
    total++;
    if (instr_o !== 32'h13 || addr_o !== 64'h2004)
      $display("FAIL sparse_head0 got=%h@%h exp=13@2004", instr_o, addr_o);
    else pass_cnt++;
    total++;
    if (is_compressed_o !== 1'b0)
      $display("FAIL sparse_rvc0 got=%0b exp=0", is_compressed_o);
    else pass_cnt++;
    ready_i = 1'b1;
    step();
    total++;
    if (instr_o !== 32'h4002 || addr_o !== 64'h200C || count_o !== 4'd1)
      $display("FAIL sparse_head1 got=%h@%h n=%0d exp=4002@200c n=1",
               instr_o, addr_o, count_o);
    else pass_cnt++;
    total++;
    if (is_compressed_o !== 1'b1)
      $display("FAIL sparse_rvc1 got=%0b exp=1", is_compressed_o);
    else pass_cnt++;
    step();
    ready_i = 1'b0;
    total++;
    if (valid_o !== 1'b0) $display("FAIL sparse_drain got=%0b exp=0", valid_o);
    else pass_cnt++;
  endtask

  // Pointers sit at 6 here: burst moved them to 4, sparse to 6.
  task automatic test_wrap();
    valid_i = 4'b1111;
    set_slots(64'h3000, 32'h3000_0003);
    step();
    valid_i = '0;
    total++;
    if (count_o !== 4'd4) $display("FAIL wrap_count got=%0d exp=4", count_o);
    else pass_cnt++;
    ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      total++;
      if (instr_o !== 32'h3000_0003 + 32'(k) ||
          addr_o !== 64'h3000 + 64'(4 * k))
        $display("FAIL wrap_order[%0d] got=%h@%h exp=%h@%h", k, instr_o,
                 addr_o, 32'h3000_0003 + 32'(k), 64'h3000 + 64'(4 * k));
      else pass_cnt++;
      step();
    end
    ready_i = 1'b0;
    total++;
    if (count_o !== 4'd0) $display("FAIL wrap_empty got=%0d exp=0", count_o);
    else pass_cnt++;
  endtask

  task automatic test_fill();
    valid_i = 4'b1111;
    set_slots(64'h4000, 32'h100);
    step();
    valid_i = 4'b0001;
    addr_i[0] = 64'h5000; instr_i[0] = 32'h200;
    total++;
    if (ready_o !== 1'b1) $display("FAIL fill_ready4 got=%0b exp=1", ready_o);
    else pass_cnt++;
    step();
    valid_i = '0;
    total++;
    if (count_o !== 4'd5 || ready_o !== 1'b0)
      $display("FAIL fill_full got=%0d/%0b exp=5/0", count_o, ready_o);
    else pass_cnt++;
    valid_i = 4'b1111;
    set_slots(64'h6000, 32'h300);
    step();
    valid_i = '0;
    total++;
    if (count_o !== 4'd5) $display("FAIL fill_drop got=%0d exp=5", count_o);
    else pass_cnt++;
    ready_i = 1'b1;
    total++;
    if (ready_o !== 1'b0)
      $display("FAIL fill_ready_pop got=%0b exp=0", ready_o);
    else pass_cnt++;
    step();
    ready_i = 1'b0;
    total++;
    if (count_o !== 4'd4 || ready_o !== 1'b1)
      $display("FAIL fill_reopen got=%0d/%0b exp=4/1", count_o, ready_o);
    else pass_cnt++;
    total++;
    if (instr_o !== 32'h101)
      $display("FAIL fill_head got=%h exp=101", instr_o);
    else pass_cnt++;
    ready_i = 1'b1;
    for (int k = 0; k < 3; k++) step();
    total++;
    if (instr_o !== 32'h200 || addr_o !== 64'h5000)
      $display("FAIL fill_tail got=%h@%h exp=200@5000", instr_o, addr_o);
    else pass_cnt++;
    step();
    ready_i = 1'b0;
    total++;
    if (count_o !== 4'd0) $display("FAIL fill_empty got=%0d exp=0", count_o);
    else pass_cnt++;
  endtask

  task automatic test_flush();
    valid_i = 4'b1111;
    set_slots(64'h7000, 32'h400);
    step();
    valid_i = 4'b0001;
    addr_i[0] = 64'h7100; instr_i[0] = 32'h500;
    step();
    total++;
    if (count_o !== 4'd5) $display("FAIL flush_pre got=%0d exp=5", count_o);
    else pass_cnt++;
    flush_i = 1'b1; ready_i = 1'b1; valid_i = 4'b1111;
    set_slots(64'hDEAD_0000, 32'hDEAD_0000);
    step();
    flush_i = 1'b0; ready_i = 1'b0; valid_i = '0;
    total++;
    if (count_o !== 4'd0 || valid_o !== 1'b0 || ready_o !== 1'b1)
      $display("FAIL flush_full got=%0d/%0b/%0b exp=0/0/1",
               count_o, valid_o, ready_o);
    else pass_cnt++;
    // flush with an acceptable push: the push must be discarded
    flush_i = 1'b1; valid_i = 4'b1111;
    step();
    flush_i = 1'b0; valid_i = '0;
    total++;
    if (count_o !== 4'd0 || valid_o !== 1'b0)
      $display("FAIL flush_push got=%0d/%0b exp=0/0", count_o, valid_o);
    else pass_cnt++;
    valid_i = 4'b0001;
    addr_i[0] = 64'h6000; instr_i[0] = 32'h600;
    step();
    valid_i = '0;
    total++;
    if (count_o !== 4'd1 || instr_o !== 32'h600 || addr_o !== 64'h6000)
      $display("FAIL flush_after got=%0d %h@%h exp=1 600@6000",
               count_o, instr_o, addr_o);
    else pass_cnt++;
    ready_i = 1'b1;
    step();
    ready_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    valid_i = 4'b1111; ready_i = 1'b1;
    set_slots(64'h9000, 32'h700);
    step();
    valid_i = '0;
    step();
    total++;
    if (count_o !== 4'd3) $display("FAIL midrst_pre got=%0d exp=3", count_o);
    else pass_cnt++;
    rst_i = 1'b1; valid_i = 4'b1111;
    step();
    rst_i = 1'b0; valid_i = '0; ready_i = 1'b0;
    total++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1 || count_o !== 4'd0)
      $display("FAIL midrst_ctl got=%0b/%0b/%0d exp=0/1/0",
               valid_o, ready_o, count_o);
    else pass_cnt++;
    total++;
    if (addr_o !== 64'h0 || instr_o !== 32'h0 || is_compressed_o !== 1'b1)
      $display("FAIL midrst_data got=%h/%h/%0b exp=0/0/1",
               addr_o, instr_o, is_compressed_o);
    else pass_cnt++;
    valid_i = 4'b0001;
    addr_i[0] = 64'h8000; instr_i[0] = 32'h13;
    step();
    valid_i = '0;
    total++;
    if (count_o !== 4'd1 || instr_o !== 32'h13 || addr_o !== 64'h8000 ||
        is_compressed_o !== 1'b0)
      $display("FAIL midrst_cold got=%0d %h@%h c=%0b exp=1 13@8000 c=0",
               count_o, instr_o, addr_o, is_compressed_o);
    else pass_cnt++;
  endtask

  initial begin
    #1;
    test_reset();
    test_burst();
    test_sparse();
    test_wrap();
    test_fill();
    test_flush();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
